// File: rtl/crc_pkg.sv
// Shared constants and FSM state type for the bit-serial CRC-8 generator.
package crc_pkg;

  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] POLY_DEFAULT = 8'h07;
  localparam logic [CRC_W-1:0] INIT_DEFAULT = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } crc_state_t;

endpackage

// File: rtl/crc8_bit_step.sv
// One MSB-first CRC-8 update step: folds a single data bit into the remainder.
module crc8_bit_step
  import crc_pkg::*;
(
  input  logic [CRC_W-1:0] i_crc,
  input  logic             i_dbit,
  input  logic [CRC_W-1:0] i_poly,
  output logic [CRC_W-1:0] o_crc
);

  logic w_fb;

  assign w_fb  = i_crc[CRC_W-1] ^ i_dbit;
  assign o_crc = {i_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? i_poly : '0);

endmodule

// File: rtl/crc_generator.sv
// Bit-serial CRC-8 generator: accepts a byte in IDLE, shifts it in over 8 cycles,
// then publishes the new running remainder on crc_byte.
module crc_generator
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = POLY_DEFAULT,
  parameter logic [CRC_W-1:0] INIT = INIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CRC_W-1:0] xData,
  input  logic             newByte,
  output logic [CRC_W-1:0] crc_byte,
  output crc_state_t       o_dbg_state
);

  crc_state_t       r_state;
  crc_state_t       w_next_state;
  logic [CRC_W-1:0] r_shift;
  logic [CRC_W-1:0] r_work;
  logic [2:0]       r_cnt;
  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] w_work_next;
  logic             w_accept;
  logic             w_last;

  crc8_bit_step u_step (
    .i_crc  (r_work),
    .i_dbit (r_shift[CRC_W-1]),
    .i_poly (POLY),
    .o_crc  (w_work_next)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (newByte) begin
          w_accept     = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        // newByte is deliberately not looked at here, even on the final bit.
        if (r_cnt == 3'd7) begin
          w_last       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_crc   <= INIT;
    end else if (w_accept) begin
      r_shift <= xData;
      r_work  <= r_crc;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_shift <= {r_shift[CRC_W-2:0], 1'b0};
      r_work  <= w_work_next;
      r_cnt   <= r_cnt + 3'd1;
      if (w_last) begin
        r_crc <= w_work_next;
      end
    end
  end

  assign crc_byte    = r_crc;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_crc_generator.sv
// Directed self-checking bench for crc_generator (CRC-8, poly 0x07, init 0x00).
module tb_crc_generator;
  import crc_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] xData;
  logic       newByte;
  logic [7:0] crc_byte;
  crc_state_t dbg_state;

  int errors = 0;
  int checks = 0;

  crc_generator dut (
    .clk         (clk),
    .reset       (reset),
    .xData       (xData),
    .newByte     (newByte),
    .crc_byte    (crc_byte),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    newByte = 1'b0;
    xData   = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the falling edge right after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    xData   = b;
    newByte = 1'b1;
    @(negedge clk);
    newByte = 1'b0;
  endtask

  task automatic send_and_settle(input logic [7:0] b);
    send_byte(b);
    wait_cycles(10);
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (crc_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_crc: got %h expected %h", crc_byte, 8'h00);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
  endtask

  // Byte 0xFF with newByte already high at reset release: accepted on the first edge.
  task automatic test_latency_ff();
    @(negedge clk);
    reset   = 1'b0;
    newByte = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    xData   = 8'hFF;
    newByte = 1'b1;
    @(negedge clk);
    newByte = 1'b0;
    xData   = 8'h5A;
    checks++;
    if (dbg_state !== SHIFT) begin
      errors++;
      $display("FAIL first_edge_accept: got %0d expected %0d", dbg_state, SHIFT);
    end
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      checks++;
      if (crc_byte !== 8'h00) begin
        errors++;
        $display("FAIL ff_hold_edge%0d: got %h expected %h", i, crc_byte, 8'h00);
      end
    end
    @(negedge clk);
    checks++;
    if (crc_byte !== 8'hF3) begin
      errors++;
      $display("FAIL ff_result: got %h expected %h", crc_byte, 8'hF3);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL ff_back_idle: got %0d expected %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_single_bytes();
    logic [7:0] din [3];
    logic [7:0] dexp [3];
    din[0] = 8'h00; dexp[0] = 8'h00;
    din[1] = 8'h01; dexp[1] = 8'h07;
    din[2] = 8'h80; dexp[2] = 8'h89;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      send_and_settle(din[i]);
      checks++;
      if (crc_byte !== dexp[i]) begin
        errors++;
        $display("FAIL single_%h: got %h expected %h", din[i], crc_byte, dexp[i]);
      end
    end
  endtask

  // xData is scrambled right after acceptance; the latched 0x80 must still be used.
  task automatic test_xdata_change();
    do_reset();
    send_byte(8'h80);
    xData = 8'hFF;
    wait_cycles(10);
    checks++;
    if (crc_byte !== 8'h89) begin
      errors++;
      $display("FAIL xdata_change: got %h expected %h", crc_byte, 8'h89);
    end
  endtask

  task automatic test_check_string();
    do_reset();
    for (int i = 0; i < 9; i++) send_and_settle(8'h31 + 8'(i));
    checks++;
    if (crc_byte !== 8'hF4) begin
      errors++;
      $display("FAIL check_123456789: got %h expected %h", crc_byte, 8'hF4);
    end
  endtask

  task automatic test_frame_residue();
    logic [7:0] fcs;
    do_reset();
    send_and_settle(8'hFF);
    for (int i = 0; i < 10; i++) send_and_settle(8'(i));
    fcs = crc_byte;
    send_and_settle(fcs);
    checks++;
    if (crc_byte !== 8'h00) begin
      errors++;
      $display("FAIL frame_residue: got %h expected %h (fcs %h)", crc_byte, 8'h00, fcs);
    end
  endtask

  // newByte held for edges 0..19: accepts at edges 0, 9, 18.
  task automatic test_back_to_back();
    crc_state_t exp_st;
    logic [7:0] exp_crc;
    do_reset();
    @(negedge clk);
    xData   = 8'h01;
    newByte = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      exp_st  = (e == 8 || e == 17) ? IDLE : SHIFT;
      exp_crc = (e < 8) ? 8'h00 : (e < 17) ? 8'h07 : 8'h12;
      checks++;
      if (dbg_state !== exp_st || crc_byte !== exp_crc) begin
        errors++;
        $display("FAIL held_edge%0d: got state %0d crc %h expected state %0d crc %h",
                 e, dbg_state, crc_byte, exp_st, exp_crc);
      end
    end
    newByte = 1'b0;
    wait_cycles(7);
    checks++;
    if (crc_byte !== 8'h79 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL held_third: got state %0d crc %h expected state %0d crc %h",
               dbg_state, crc_byte, IDLE, 8'h79);
    end
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    send_and_settle(8'h01);
    send_byte(8'hFF);
    wait_cycles(3);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (crc_byte !== 8'h00 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL midshift_async_reset: got state %0d crc %h expected state %0d crc %h",
               dbg_state, crc_byte, IDLE, 8'h00);
    end
    wait_cycles(2);
    reset = 1'b1;
    send_and_settle(8'h01);
    checks++;
    if (crc_byte !== 8'h07) begin
      errors++;
      $display("FAIL after_abort: got %h expected %h", crc_byte, 8'h07);
    end
  endtask

  initial begin
    reset   = 1'b0;
    newByte = 1'b0;
    xData   = 8'h00;
    test_reset();
    test_latency_ff();
    test_single_bytes();
    test_xdata_change();
    test_check_string();
    test_frame_residue();
    test_back_to_back();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
